crc_src_capture: RTL and testbench
==================================

# crc_src_capture

Source-domain capture stage for the CRC datapath, replacing the single-register capture with a parametrised buffer. It accepts input patterns (message, mode, CRC) on `in_valid`, queues up to `DEPTH` of them and launches them one at a time across the clock-domain boundary. Each launch uses a toggle request (`clk1_flag`) and a returned toggle acknowledge (`ack_tgl`). It sits in the clk_1 domain in front of the destination-domain CRC engine, and no pattern is lost while the destination is busy, up to the buffer depth.

## Interface
- `MSG_W`, default 60: message width in bits.
- `DEPTH`, default 4: buffer entries; power of two, ≥2.
- `SYNC_STAGES`, default 2: flops in the `ack_tgl` synchroniser; ≥2.
- `clk_1` input 1: sole clock. All logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: pattern present this cycle.
- `message` input MSG_W: message payload.
- `mode` input 1: CRC mode bit.
- `CRC` input 1: CRC-check select bit.
- `ack_tgl` input 1: acknowledge toggle from the destination domain. Asynchronous to `clk_1`.
- `in_ready` output 1: buffer not full (`count < DEPTH`).
- `clk1_message` output MSG_W: launched message. Registered; stable while a request is outstanding.
- `clk1_mode` output 1: launched mode. Registered.
- `clk1_CRC` output 1: launched CRC bit. Registered.
- `clk1_flag` output 1: request toggle level. Inverts once per launch.
- `busy` output 1: request outstanding (state REQ).
- `count` output $clog2(DEPTH+1): buffer occupancy.
- `overflow` output 1: sticky; a pattern was dropped.
- `drop_cnt` output 8: saturating count of dropped patterns.

## Operation
- **Buffer.** Circular FIFO of {message, mode, CRC} with rd/wr pointers of width log2(DEPTH).
  - Pointers wrap from DEPTH-1 to 0.
  - `count` tracks occupancy from 0 to DEPTH.
- **Push.** A push is `in_valid` & (`count < DEPTH` | pop in the same cycle).
  - Push while full with a simultaneous pop is accepted, and `count` stays DEPTH.
- **Drop.** A drop is `in_valid` & `count == DEPTH` & no pop.
  - The pattern is discarded and `overflow` is set (sticky until reset).
  - `drop_cnt` increments and saturates at 255.
- **Ack synchroniser.** `ack_tgl` passes through SYNC_STAGES flops to give `ack_s`.
  - An ack is complete when `ack_s == clk1_flag`.
- **FSM states:** IDLE, REQ.
  - **IDLE.** If `count > 0`, pop the head into the `clk1_*` registers, invert `clk1_flag` and go to REQ. Otherwise stay in IDLE.
  - **REQ.** Outputs are held. When `ack_s == clk1_flag`, go to IDLE. No pop happens on the transition cycle.
- Push and pop in the same cycle leaves `count` unchanged, and the popped entry is the old head.
- With an empty FIFO and `in_valid` asserted, the pattern is written first. There is no bypass.

## Timing
- **Reset.** All outputs reset to 0 while `rst_n` is low, except `in_ready`, which is 1 (empty).
  - FSM resets to IDLE, pointers to 0, synchroniser flops to 0.
- **Reset mid-operation.** Any queued or outstanding pattern is discarded.
  - The destination side must also be reset, so that `ack_tgl` returns to 0.
- **Launch latency.** `in_valid` sampled at edge N with an empty FIFO and IDLE state:
  - `count` = 1 after edge N.
  - Pop and launch at edge N+1: new `clk1_*` and inverted `clk1_flag` are visible after edge N+1.
- **Ack latency.** If `ack_tgl` changes before edge M, `ack_s` matches after edge M+SYNC_STAGES-1.
  - FSM is in IDLE after the following edge.
  - The next launch is at the edge after that.
- **Output stability.** `clk1_message`, `clk1_mode` and `clk1_CRC` change only on the cycle that `clk1_flag` inverts.
- `in_ready` and `count` update on the edge after a push or pop.

## Test plan
- **Reset values.** Assert `rst_n`=0 mid-cycle with no clock. Outputs are 0 immediately and `in_ready` is 1.
- **Single pattern.** Send `message`=60'h123_4567_89AB_CDEF, `mode`=1, `CRC`=0.
  - `clk1_flag` is 0→1 two edges after `in_valid` and `clk1_message` matches.
  - Return `ack_tgl`=1. `busy` falls SYNC_STAGES+1 edges later.
- **Burst while busy.** With `ack_tgl` held, push 4 patterns (A,B,C,D) back-to-back.
  - Only A is launched; `count` peaks at 3.
  - Toggle the ack 3 times. B, C, D launch in order, one per ack, and `clk1_flag` inverts each time.
- **Overflow.** Hold `ack_tgl` and push 7 patterns with DEPTH=4.
  - 1 is in flight, 4 are buffered, `in_ready`=0.
  - `overflow`=1 and `drop_cnt`=2. The two dropped are the last two pushed.
- **Full push + pop.** With `count`=4 in REQ, toggle the ack and push E on the pop cycle.
  - `count` stays 4, E is queued, and `drop_cnt` is unchanged.
- **drop_cnt saturation and reset mid-REQ.**
  - 300 drops give `drop_cnt`=255.
  - Asserting `rst_n`=0 in REQ returns to IDLE with `count`=0 and `clk1_flag`=0.

Source files
------------

// File: rtl/crc_src_capture.sv
// crc_src_capture: clk_1-domain capture buffer for the CRC datapath.
// Queues {message, mode, CRC} patterns in a small circular FIFO and launches
// them one at a time to the destination domain with a toggle request
// (clk1_flag) and a synchronised toggle acknowledge (ack_tgl).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request outstanding; pops the FIFO head when count > 0
// REQ   | request outstanding; clk1_* held until ack_s == clk1_flag
module crc_src_capture #(
    parameter int MSG_W       = 60,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk_1,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [MSG_W-1:0]           message,
    input  logic                       mode,
    input  logic                       CRC,
    input  logic                       ack_tgl,
    output logic                       in_ready,
    output logic [MSG_W-1:0]           clk1_message,
    output logic                       clk1_mode,
    output logic                       clk1_CRC,
    output logic                       clk1_flag,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [MSG_W-1:0]       mem_msg  [DEPTH];
    logic                   mem_mode [DEPTH];
    logic                   mem_crc  [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   ack_done;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic                   full;

    assign ack_s    = ack_sync[SYNC_STAGES-1];
    assign ack_done = (ack_s == clk1_flag);
    assign full     = (count == FULL);
    assign push     = in_valid && (!full || pop);
    assign drop     = in_valid && full && !pop;
    assign in_ready = !full;
    assign busy     = (state == REQ);

    // Bring the destination's acknowledge toggle into clk_1.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_tgl};
        end
    end

    // FSM state register.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and pop decision; the REQ->IDLE cycle never pops.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ack_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Payload storage; contents are only meaningful between wr_ptr and rd_ptr.
    always_ff @(posedge clk_1) begin
        if (push) begin
            mem_msg[wr_ptr]  <= message;
            mem_mode[wr_ptr] <= mode;
            mem_crc[wr_ptr]  <= CRC;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count alone.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Launch registers: loaded and the request toggled only on a pop.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            clk1_message <= '0;
            clk1_mode    <= 1'b0;
            clk1_CRC     <= 1'b0;
            clk1_flag    <= 1'b0;
        end else if (pop) begin
            clk1_message <= mem_msg[rd_ptr];
            clk1_mode    <= mem_mode[rd_ptr];
            clk1_CRC     <= mem_crc[rd_ptr];
            clk1_flag    <= ~clk1_flag;
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_crc_src_capture.sv
// tb_crc_src_capture: directed checks of the crc_src_capture buffer/launcher
// with DEPTH=4 and SYNC_STAGES=2.
module tb_crc_src_capture;

    logic        clk_1;
    logic        clk_en;
    logic        rst_n;
    logic        in_valid;
    logic [59:0] message;
    logic        mode;
    logic        CRC;
    logic        ack_tgl;
    logic        in_ready;
    logic [59:0] clk1_message;
    logic        clk1_mode;
    logic        clk1_CRC;
    logic        clk1_flag;
    logic        busy;
    logic [2:0]  count;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int vectors;
    int miscompares;

    localparam logic [59:0] M1 = 60'h123_4567_89AB_CDEF;
    localparam logic [59:0] PA = 60'hA0A_0A0A_0A0A_0A0A;
    localparam logic [59:0] PB = 60'hB1B_1B1B_1B1B_1B1B;
    localparam logic [59:0] PC = 60'hC2C_2C2C_2C2C_2C2C;
    localparam logic [59:0] PD = 60'hD3D_3D3D_3D3D_3D3D;
    localparam logic [59:0] PE = 60'hE4E_4E4E_4E4E_4E4E;

    crc_src_capture #(
        .MSG_W       (60),
        .DEPTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk_1        (clk_1),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .message      (message),
        .mode         (mode),
        .CRC          (CRC),
        .ack_tgl      (ack_tgl),
        .in_ready     (in_ready),
        .clk1_message (clk1_message),
        .clk1_mode    (clk1_mode),
        .clk1_CRC     (clk1_CRC),
        .clk1_flag    (clk1_flag),
        .busy         (busy),
        .count        (count),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt)
    );

    initial clk_1 = 1'b0;
    always #5 if (clk_en) clk_1 = ~clk_1;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_1);
    endtask

    task automatic drive(input logic [59:0] m, input logic md, input logic cr);
        in_valid = 1'b1;
        message  = m;
        mode     = md;
        CRC      = cr;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        ack_tgl  = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Return the ack for the outstanding request and expect the next launch
    // exactly four edges later.
    task automatic ack_and_expect(inout logic ef, input logic [59:0] m, input logic [2:0] cnt);
        ack_tgl = ef;
        repeat (3) tick();
        check("launch_not_early", 64'(clk1_flag), 64'(ef));
        tick();
        ef = ~ef;
        check("launch_flag", 64'(clk1_flag), 64'(ef));
        check("launch_msg", 64'(clk1_message), 64'(m));
        check("launch_count", 64'(count), 64'(cnt));
    endtask

    logic        exp_flag;
    logic [59:0] pat [1:7];

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk_en      = 1'b0;
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        message     = '0;
        mode        = 1'b0;
        CRC         = 1'b0;
        ack_tgl     = 1'b0;
        for (int i = 1; i <= 7; i++) pat[i] = 60'h100 + 60'(i);

        // Reset values with no clock running.
        #3 rst_n = 1'b0;
        #1;
        check("rst_message", 64'(clk1_message), 64'h0);
        check("rst_mode", 64'(clk1_mode), 64'h0);
        check("rst_crc", 64'(clk1_CRC), 64'h0);
        check("rst_flag", 64'(clk1_flag), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_count", 64'(count), 64'h0);
        check("rst_overflow", 64'(overflow), 64'h0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        clk_en = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        // Single pattern.
        drive(M1, 1'b1, 1'b0);
        check("single_count1", 64'(count), 64'h1);
        check("single_flag_pre", 64'(clk1_flag), 64'h0);
        tick();
        check("single_flag", 64'(clk1_flag), 64'h1);
        check("single_msg", 64'(clk1_message), 64'(M1));
        check("single_mode", 64'(clk1_mode), 64'h1);
        check("single_crc", 64'(clk1_CRC), 64'h0);
        check("single_busy", 64'(busy), 64'h1);
        check("single_count0", 64'(count), 64'h0);
        ack_tgl = 1'b1;
        tick();
        check("single_busy_m", 64'(busy), 64'h1);
        tick();
        check("single_busy_m1", 64'(busy), 64'h1);
        tick();
        check("single_busy_fall", 64'(busy), 64'h0);

        // Burst while busy.
        drive(PA, 1'b0, 1'b1);
        check("burst_count_a", 64'(count), 64'h1);
        drive(PB, 1'b1, 1'b1);
        check("burst_launch_a", 64'(clk1_message), 64'(PA));
        check("burst_flag_a", 64'(clk1_flag), 64'h0);
        check("burst_crc_a", 64'(clk1_CRC), 64'h1);
        check("burst_count_b", 64'(count), 64'h1);
        drive(PC, 1'b0, 1'b0);
        drive(PD, 1'b1, 1'b0);
        check("burst_count_peak", 64'(count), 64'h3);
        check("burst_hold_a", 64'(clk1_message), 64'(PA));
        exp_flag = 1'b0;
        ack_and_expect(exp_flag, PB, 3'd2);
        check("burst_mode_b", 64'(clk1_mode), 64'h1);
        ack_and_expect(exp_flag, PC, 3'd1);
        ack_and_expect(exp_flag, PD, 3'd0);
        ack_tgl = exp_flag;
        repeat (3) tick();
        check("burst_idle", 64'(busy), 64'h0);

        // Overflow: 1 in flight, 4 buffered, 2 dropped.
        do_reset();
        for (int i = 1; i <= 7; i++) drive(pat[i], 1'b0, 1'b0);
        check("ovf_count", 64'(count), 64'h4);
        check("ovf_in_ready", 64'(in_ready), 64'h0);
        check("ovf_flag", 64'(overflow), 64'h1);
        check("ovf_drop_cnt", 64'(drop_cnt), 64'h2);
        check("ovf_inflight", 64'(clk1_message), 64'(pat[1]));

        // Full push + pop on the same edge.
        ack_tgl = 1'b1;
        repeat (3) tick();
        check("fpp_idle", 64'(busy), 64'h0);
        check("fpp_count_pre", 64'(count), 64'h4);
        drive(PE, 1'b1, 1'b1);
        check("fpp_count", 64'(count), 64'h4);
        check("fpp_drop_cnt", 64'(drop_cnt), 64'h2);
        check("fpp_launch", 64'(clk1_message), 64'(pat[2]));
        check("fpp_busy", 64'(busy), 64'h1);
        exp_flag = 1'b0;
        ack_and_expect(exp_flag, pat[3], 3'd3);
        ack_and_expect(exp_flag, pat[4], 3'd2);
        ack_and_expect(exp_flag, pat[5], 3'd1);
        ack_and_expect(exp_flag, PE, 3'd0);
        check("fpp_e_mode", 64'(clk1_mode), 64'h1);

        // drop_cnt saturation: 4 fills then drops on top of the existing 2.
        for (int i = 0; i < 256; i++) drive(60'(i), 1'b0, 1'b0);
        check("sat_254", 64'(drop_cnt), 64'd254);
        drive(60'h5A5, 1'b0, 1'b0);
        check("sat_255", 64'(drop_cnt), 64'd255);
        for (int i = 0; i < 47; i++) drive(60'(i), 1'b0, 1'b0);
        check("sat_hold", 64'(drop_cnt), 64'd255);
        check("sat_count", 64'(count), 64'h4);
        check("sat_busy", 64'(busy), 64'h1);

        // Reset in the middle of REQ.
        #2 rst_n = 1'b0;
        ack_tgl = 1'b0;
        #1;
        check("rreq_busy", 64'(busy), 64'h0);
        check("rreq_count", 64'(count), 64'h0);
        check("rreq_flag", 64'(clk1_flag), 64'h0);
        check("rreq_in_ready", 64'(in_ready), 64'h1);
        check("rreq_drop_cnt", 64'(drop_cnt), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        drive(M1, 1'b0, 1'b1);
        tick();
        check("post_rst_flag", 64'(clk1_flag), 64'h1);
        check("post_rst_msg", 64'(clk1_message), 64'(M1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
